// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming frame parity unit.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESULT
  } state_e;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/parity_word_reduce.sv
// Combinational XOR reduction of one DATA_W-bit word down to its parity bit.
module parity_word_reduce #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/parity_frame_unit.sv
// Streaming frame parity generator/checker with valid/ready on both sides.
// Optional feature macro: PARITY_ERR_CNT_EN adds a saturating err_cnt output.
module parity_frame_unit
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 16,
  localparam int LEN_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_odd,
  input  logic              check_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_ovf
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_e            state_q, state_d;
  logic              acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              odd_q, odd_d;
  logic              chk_q, chk_d;
  logic              par_q, par_d;
  logic              ovf_q, ovf_d;
  logic              word_par;
  logic              accept;
  logic [LEN_W-1:0]  cnt_inc;

  parity_word_reduce #(
    .DATA_W (DATA_W)
  ) u_reduce (
    .data_i (in_data),
    .par_o  (word_par)
  );

  assign in_ready  = (state_q != RESULT);
  assign out_valid = (state_q == RESULT);
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    chk_d   = chk_q;
    par_d   = par_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = word_par;
          cnt_d = LEN_W'(1);
          odd_d = mode_odd;
          chk_d = check_mode;
          par_d = 1'b0;
          ovf_d = 1'b0;
          if (in_last) begin
            par_d   = in_par;
            state_d = RESULT;
          end else if (MAX_WORDS == 1) begin
            ovf_d   = 1'b1;
            state_d = RESULT;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = acc_q ^ word_par;
          cnt_d = cnt_inc;
          if (in_last) begin
            par_d   = in_par;
            state_d = RESULT;
          end else if (cnt_inc == LEN_W'(MAX_WORDS)) begin
            // A forced termination has no received parity bit to compare.
            par_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      odd_q   <= 1'b0;
      chk_q   <= 1'b0;
      par_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      chk_q   <= chk_d;
      par_q   <= par_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result fields read as zero whenever no result is being offered.
  assign out_par = out_valid & ~chk_q & (acc_q ^ odd_q);
  assign out_err = out_valid & chk_q & (acc_q ^ par_q ^ odd_q);
  assign out_len = out_valid ? cnt_q : '0;
  assign out_ovf = out_valid & ovf_q;

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/parity_frame_unit.md
Name: parity_frame_unit

Overview:
Streaming, parametrised successor to the combinational 3-input parity generator. Accepts DATA_W-bit words over a valid/ready handshake and accumulates parity across a multi-word frame terminated by in_last. Per frame it either generates the even/odd parity bit (generate mode) or checks a received parity bit (check mode). Sits between a word source and a framing/transmit stage; one result is emitted per frame.

Parameters:
DATA_W, 8, width of each input word (>=1)
MAX_WORDS, 16, maximum words per frame; reaching it without in_last force-terminates the frame (>=1)
LEN_W, $clog2(MAX_WORDS+1), width of out_len (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode_odd  input  1  0 = even parity, 1 = odd parity; sampled on the first accepted word of a frame
check_mode  input  1  0 = generate, 1 = check; sampled on the first accepted word of a frame
in_valid  input  1  source has a word
in_ready  output  1  block accepts a word this cycle
in_data  input  DATA_W  word payload
in_last  input  1  final word of the frame
in_par  input  1  received parity bit; meaningful only with in_last in check mode
out_valid  output  1  frame result available
out_ready  input  1  sink accepts the result
out_par  output  1  generated parity bit (generate mode); 0 in check mode
out_err  output  1  parity mismatch (check mode); 0 in generate mode
out_len  output  LEN_W  number of words in the frame
out_ovf  output  1  frame was force-terminated at MAX_WORDS

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low. Reset forces state IDLE, and clears the accumulator, word count, and all mode and result registers.
- Reset output values: in_ready=1, out_valid=0, out_par=0, out_err=0, out_len=0, out_ovf=0.
- A word transfers when in_valid & in_ready on a rising edge. A result transfers when out_valid & out_ready.
- FSM states: IDLE, ACC, RESULT.
  - IDLE: in_ready=1. On a transfer:
    - load acc = ^in_data, cnt=1, and latch mode_odd and check_mode;
    - if in_last, latch in_par and go to RESULT;
    - else if MAX_WORDS==1, go to RESULT with ovf=1;
    - else go to ACC.
  - ACC: in_ready=1. On a transfer, acc ^= ^in_data and cnt++.
    - If in_last, latch in_par and go to RESULT.
    - Else if the new cnt==MAX_WORDS, go to RESULT with ovf=1; in_par is treated as 0.
    - mode_odd and check_mode changes during ACC are ignored.
  - RESULT: in_ready=0, out_valid=1. All out_* held stable until the output transfer, then go to IDLE.
- No bypass: after a result handshake the next word is accepted one cycle later at the earliest.
- Result values:
  - Generate mode: out_par = acc ^ odd.
  - Check mode: out_err = acc ^ in_par_l ^ odd.
  - out_len = cnt.
- Latency: out_valid rises on the clock edge that accepts the last word, i.e. visible the cycle after the last-word handshake.
- in_last together with the MAX_WORDS-th word is a normal termination: ovf=0.
- Reset asserted mid-frame or in RESULT discards the frame; no result is emitted.
- Throughput: one word per cycle in IDLE/ACC; one dead cycle minimum per frame (RESULT).

Optional Feature:
PARITY_ERR_CNT_EN
- Defined: adds output err_cnt [15:0], a saturating count of check-mode results transferred with out_err=1.
  - Increments on the output handshake; holds at 16'hFFFF.
  - Cleared by rst_n only.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package parity_pkg: state enum type (IDLE, ACC, RESULT) and the err_cnt width constant (16).
- One sub-module, parity_word_reduce: a parametrised combinational XOR reduction of a DATA_W word. Instantiated once, driving the ^in_data term.

Test Plan:
- Even, generate, DATA_W=8: words 0x96, 0x01(last) -> out_par=1, out_len=2, out_err=0, out_ovf=0, out_valid the cycle after the second handshake.
- Same frame with mode_odd=1 at the first word, and mode_odd toggled mid-frame -> out_par=0; the mid-frame toggle has no effect.
- Check mode, even: 0x07(last) with in_par=1 -> out_err=0. Repeat with in_par=0 -> out_err=1.
- MAX_WORDS=4: four words, in_last never asserted -> out_ovf=1, out_len=4. A fifth word is held off (in_ready=0) until the result handshake.
- out_ready low for 3 cycles in RESULT -> out_* stable, in_ready=0. After the handshake, in_ready=1 next cycle and the next frame starts cleanly.
- rst_n pulsed low mid-frame after 2 words -> outputs return to reset values immediately. A following single-word frame 0xFF(last), even generate -> out_par=0, out_len=1.
